// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT/DIV engine: shift-add multiply, restoring divide, HI/LO out.
// Define DIV_ZERO_EXC_EN to trap divide-by-zero with a div_zero pulse instead of running it.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mcand;
  logic             neg_q;
  logic             neg_r;
  logic             is_div;

  logic             accept;
  logic             b_zero;
  logic             dz_trap;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign accept = start && (state == IDLE || state == DONE);
  assign b_zero = (b == '0);
  assign a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;

`ifdef DIV_ZERO_EXC_EN
  logic dz_q;

  assign dz_trap  = accept && op_div && b_zero;
  assign div_zero = dz_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) dz_q <= 1'b0;
    else       dz_q <= dz_trap;
  end
`else
  assign dz_trap  = 1'b0;
  assign div_zero = 1'b0;
`endif

  assign busy = (state == MUL) || (state == DIV) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (!accept)      state_n = IDLE;
        else if (dz_trap) state_n = IDLE;
        else if (op_div)  state_n = DIV;
        else              state_n = MUL;
      end
      MUL, DIV: begin
        if (cnt == CW'(1)) state_n = FIX;
      end
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ok;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  assign mul_sum  = {1'b0, acc_hi}
                  + {1'b0, (acc_lo[0] ? mcand : {WIDTH{1'b0}})};
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ok   = (div_sh >= {1'b0, mcand});
  // true difference is below 2^WIDTH whenever it is kept
  assign div_sub  = div_sh[WIDTH-1:0] - mcand;
  assign prod     = {acc_hi, acc_lo};
  assign prod_neg = ~prod + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept && !dz_trap) begin
            cnt    <= CW'(WIDTH);
            acc_hi <= '0;
            acc_lo <= op_div ? a_mag : b_mag;
            mcand  <= op_div ? b_mag : a_mag;
            // a zero divisor leaves quotient all-ones unsigned, rem back to a
            neg_q  <= (a[WIDTH-1] ^ b[WIDTH-1]) && !(op_div && b_zero);
            neg_r  <= a[WIDTH-1];
            is_div <= op_div;
          end
        end
        MUL: begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          cnt <= cnt - 1'b1;
        end
        DIV: begin
          acc_hi <= div_ok ? div_sub : div_sh[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          cnt    <= cnt - 1'b1;
        end
        FIX: begin
          if (is_div) begin
            lo <= neg_q ? (~acc_lo + 1'b1) : acc_lo;
            hi <= neg_r ? (~acc_hi + 1'b1) : acc_hi;
          end else begin
            {hi, lo} <= neg_q ? prod_neg : prod;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed MULT/DIV vectors,
// back-to-back issue, mid-op reset and divide-by-zero handling.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op_div = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op_div   (op_div),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
    string        name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc  = 0;
  int   nvec = 0;
  int   nbad = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (done === 1'b1) begin
      nvec++;
      if (q.size() == 0) begin
        nbad++;
        $display("FAIL unexpected_done: got done=1 at cyc %0d, want none", cyc);
      end else begin
        mon_e = q.pop_front();
        if (hi !== mon_e.hi || lo !== mon_e.lo || cyc != mon_e.due ||
            busy !== 1'b0 || div_zero !== 1'b0) begin
          nbad++;
          $display("FAIL %s: got hi=%h lo=%h cyc=%0d busy=%b dz=%b want hi=%h lo=%h cyc=%0d busy=0 dz=0",
                   mon_e.name, hi, lo, cyc, busy, div_zero,
                   mon_e.hi, mon_e.lo, mon_e.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    nvec++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // call just after a negedge; returns one negedge later
  task automatic issue(input bit d, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input string nm,
                       input bit expect_done);
    exp_t e;
    start  = 1'b1;
    op_div = d;
    a      = x;
    b      = y;
    if (expect_done) begin
      e.hi   = eh;
      e.lo   = el;
      e.due  = cyc + W + 2;
      e.name = nm;
      q.push_back(e);
    end
    @(negedge clock);
    start  = 1'b0;
    op_div = 1'($urandom);
    a      = $urandom;
    b      = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && q.size() != 0; i++) begin
      @(negedge clock);
      #1;
    end
    if (q.size() != 0) begin
      nvec++;
      nbad++;
      $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      #1;
      if (done === 1'b1) seen = 1;
    end
    if (!seen) begin
      nvec++;
      nbad++;
      $display("FAIL wait_done: got no done, want done within 60 cycles");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_dz", W'(div_zero), '0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    reset = 1'b0;
    @(negedge clock);

    issue(0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mul_7_m3", 1);
    drain();
    issue(0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mul_min_min", 1);
    drain();
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mul_m1_m1", 1);
    drain();
    issue(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, "mul_max_max", 1);
    drain();
    issue(0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, "mul_zero", 1);
    drain();
    issue(0, 32'h0000_3039, 32'h0000_1A85, 32'h0000_0000, 32'h04FE_D79D, "mul_12345_6789", 1);
    drain();

    issue(1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2", 1);
    wait_done();
    issue(1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, "div_b2b_100_7", 1);
    drain();

    issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_m1", 1);
    drain();
    issue(1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_m2", 1);
    drain();
    issue(1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, "div_m7_m2", 1);
    drain();
    issue(1, 32'h0000_0003, 32'h0000_000A, 32'h0000_0003, 32'h0000_0000, "div_3_10", 1);
    drain();

`ifdef DIV_ZERO_EXC_EN
    issue(1, 32'h0000_0005, 32'h0000_0000, '0, '0, "div_5_0", 0);
    chk("dz_pulse", W'(div_zero), 32'd1);
    chk("dz_busy", W'(busy), '0);
    @(negedge clock);
    chk("dz_one_cycle", W'(div_zero), '0);
    repeat (40) @(negedge clock);
    chk("dz_hold_hi", hi, 32'h0000_0003);
    chk("dz_hold_lo", lo, 32'h0000_0000);
`else
    issue(1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, "div_5_0", 1);
    drain();
    issue(1, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_m7_0", 1);
    drain();
`endif

    issue(1, 32'h0000_0064, 32'h0000_0007, '0, '0, "div_aborted", 0);
    repeat (8) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_hi", hi, '0);
    chk("arst_lo", lo, '0);
    chk("arst_busy", W'(busy), '0);
    chk("arst_done", W'(done), '0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);

    issue(0, 32'hFFFF_FFFE, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF6, "mul_after_rst", 1);
    drain();
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
